// File: rtl/sysmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sysmem_arbiter
// Purpose  : Shares four byte-lane system RAM instances between the cpu
//            native memory port and the debug/boot loader port. One
//            transaction at a time, IDLE -> ACCESS -> RESP, with window
//            decode and an error pulse for out-of-window accesses.
// Revision : 1.0 - initial release
// ============================================================================
module sysmem_arbiter #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LD_PRIO   = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [3:0]        ld_wstrb,
  output logic              ld_ready,
  output logic [31:0]       ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_ce,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_di,
  input  logic [31:0]       ram_do,
  output logic              err
);

  localparam int   TAG_LSB   = ADDR_W + 2;
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_LD  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        grant;       // requester owning the current transaction
  logic        last_grant;  // requester served most recently
  logic        hit;         // current transaction falls inside the window
  logic        is_write;    // current transaction has a non-zero strobe

  logic        any_req;
  logic        pick_ld;
  logic        sel_hit;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        in_resp;
  logic [31:0] resp_data;
  logic        unused_addr_lsbs;

  // Arbitration: choose the requester and mux its request fields.
  always_comb begin
    any_req = cpu_valid | ld_valid;
    pick_ld = GRANT_CPU;
    if (cpu_valid && ld_valid) begin
      // Round-robin hands a tie to whoever was not served last.
      pick_ld = (LD_PRIO != 0) ? GRANT_LD : ~last_grant;
    end else if (ld_valid) begin
      pick_ld = GRANT_LD;
    end
    sel_addr  = pick_ld ? ld_addr  : cpu_addr;
    sel_wdata = pick_ld ? ld_wdata : cpu_wdata;
    sel_wstrb = pick_ld ? ld_wstrb : cpu_wstrb;
    sel_hit   = (sel_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  end

  // Byte offset within a word plays no part in word-wide lane access.
  assign unused_addr_lsbs = ^sel_addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: every transaction is exactly three cycles long.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the granted request and present lane enables during ACCESS only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= GRANT_CPU;
      last_grant <= GRANT_LD;
      hit        <= 1'b0;
      is_write   <= 1'b0;
      ram_addr   <= '0;
      ram_di     <= 32'h0;
      ram_ce     <= 4'h0;
      ram_we     <= 4'h0;
    end else begin
      ram_ce <= 4'h0;
      ram_we <= 4'h0;
      if (state == S_IDLE && any_req) begin
        grant      <= pick_ld;
        last_grant <= pick_ld;
        hit        <= sel_hit;
        is_write   <= (sel_wstrb != 4'h0);
        ram_addr   <= sel_addr[ADDR_W+1:2];
        ram_di     <= sel_wdata;
        if (sel_hit) begin
          ram_ce <= (sel_wstrb == 4'h0) ? 4'hF : sel_wstrb;
          ram_we <= sel_wstrb;
        end
      end
    end
  end

  // Response side decodes purely from registered state, plus lane data.
  assign in_resp   = (state == S_RESP);
  assign resp_data = (in_resp && hit && !is_write) ? ram_do : 32'h0;
  assign cpu_ready = in_resp && (grant == GRANT_CPU);
  assign ld_ready  = in_resp && (grant == GRANT_LD);
  assign cpu_rdata = cpu_ready ? resp_data : 32'h0;
  assign ld_rdata  = ld_ready  ? resp_data : 32'h0;
  assign err       = in_resp && !hit;

endmodule
`default_nettype wire

// File: doc/sysmem_arbiter.md
Name: sysmem_arbiter

Overview:
- Sequences and shares the on-chip system RAM between the picorv32 native memory port (cpu) and a debug/boot loader port (ld).
- The RAM is four 1024x8 single-port byte-lane instances of the sysmem family, with lane k holding data bits [8k+7:8k].
- The instances are non-registered: read data is valid the cycle after the enabled clock edge.
- The arbiter grants one requester at a time, drives the shared address, per-lane enables and write strobes, returns read data, and flags out-of-window accesses.

Parameters:
- ADDR_W, 10, word address width of each byte-lane RAM (depth = 2^ADDR_W words).
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to 2^(ADDR_W+2).
- LD_PRIO, 0, 0 = round-robin between cpu and ld; 1 = ld has fixed priority.

Ports:
- clk  in  1  system clock; all RAM lanes use this clock.
- resetn  in  1  asynchronous active-low reset.
- cpu_valid  in  1  cpu request; held until cpu_ready.
- cpu_addr  in  32  cpu byte address; bits [1:0] ignored.
- cpu_wdata  in  32  cpu write data.
- cpu_wstrb  in  4  cpu byte write strobes; 0 = read.
- cpu_ready  out  1  one-cycle completion pulse to cpu.
- cpu_rdata  out  32  cpu read data, valid while cpu_ready=1.
- ld_valid, ld_addr, ld_wdata, ld_wstrb, ld_ready, ld_rdata  same directions, widths and meanings as the cpu_* group, for the loader.
- ram_addr  out  ADDR_W  shared word address to all four lanes.
- ram_ce  out  4  per-lane chip enable.
- ram_we  out  4  per-lane write enable.
- ram_di  out  32  write data to lanes.
- ram_do  in  32  concatenated lane read data.
- err  out  1  one-cycle pulse on a completed out-of-window access.

Behaviour:
- Reset (async, resetn=0): state=IDLE; ram_ce=0, ram_we=0, ram_addr=0, ram_di=0; cpu_ready=ld_ready=0; err=0; rdata outputs=0; last_grant=ld, so cpu wins the first tie.
- Reset asserted mid-access drops ram_ce/ram_we immediately. A write whose enabling edge has not yet occurred is aborted. No ready pulse is issued for the aborted transaction.
- FSM states: IDLE, ACCESS, RESP. Every transaction takes exactly IDLE -> ACCESS -> RESP -> IDLE.
- IDLE arbitration, evaluated on each edge in IDLE:
  - One valid: grant it.
  - Both valid with LD_PRIO=0: grant the requester not equal to last_grant.
  - Both valid with LD_PRIO=1: grant ld.
  - On grant, register grant, last_grant, hit, ram_addr = addr[ADDR_W+1:2] and ram_di = wdata; go to ACCESS.
  - No valid: stay in IDLE; ram_ce=0.
- hit = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
- ACCESS (1 cycle), registered outputs:
  - hit and wstrb=0: ram_ce=4'hF, ram_we=0.
  - hit and wstrb!=0: ram_ce=wstrb, ram_we=wstrb.
  - Miss: ram_ce=0, ram_we=0.
  - Next state is RESP; ram_ce/ram_we return to 0 in RESP.
- RESP (1 cycle):
  - The granted requester's ready=1; the other requester's ready stays 0.
  - rdata = ram_do for a hit read, 32'h0 for a write or a miss.
  - err=1 only on a miss.
  - Next state is IDLE.
- ready, rdata and err are decoded from registered state only, with no combinational path from any *_valid input.
- Latency: valid first seen high in cycle N (in IDLE) -> ram_ce in N+1 -> ready in N+2. Peak throughput is one access per 3 cycles.
- The loser of a tie keeps its valid high and is granted on the next IDLE. It cannot be starved when LD_PRIO=0.
- Valid dropped before ready (protocol violation): the transaction still completes and ready still pulses.
- A requester that re-asserts valid in the cycle after ready is seen in that IDLE cycle.
- Writes with partial strobes modify only the strobed lanes; other lanes' contents are unchanged.
- Write with wstrb=4'h0 does not exist; it is a read by definition.

Test Plan:
- Reset then cpu write addr=0x0000_0010, wdata=0xDEADBEEF, wstrb=F; then cpu read 0x10 -> ram_addr=4 in ACCESS, ram_we=F on write, read returns 0xDEADBEEF; ready pulses 2 cycles after valid, each one cycle wide.
- Partial write addr=0x10 wdata=0x000000AA wstrb=4'b0001 after the full write -> ram_ce=ram_we=0001; readback 0xDEADBEAA.
- cpu and ld valid in the same cycle, LD_PRIO=0, repeated 4 times -> grants alternate cpu, ld, cpu, ld; each ready fires exactly once per request; the other requester's ready stays 0.
- Same stimulus with LD_PRIO=1 -> ld granted first every tie; cpu is granted only on the IDLE where ld_valid=0.
- cpu read at 0x0000_1000 (outside a 4 KB window at BASE 0) -> ram_ce stays 0 throughout, cpu_rdata=0, err=1 for exactly one cycle coincident with cpu_ready.
- Assert resetn=0 during ACCESS of a write to addr 0x20 -> ram_ce/ram_we drop immediately, no ready pulse, state=IDLE; a subsequent read of 0x20 returns the pre-reset value.
